// File: rtl/ddr_port_arbiter_if.sv
// Bus bundle between the DDR port arbiter, its two requesters and the memory controller.
// The arbiter connects through the slave modport; the requester/controller side uses master.
interface ddr_port_arbiter_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 32
);
  logic              pause;
  logic              cam_req;
  logic [ADDR_W-1:0] cam_addr;
  logic [DATA_W-1:0] cam_wdata;
  logic              cam_urgent;
  logic              cam_gnt;
  logic              proc_req;
  logic              proc_we;
  logic [ADDR_W-1:0] proc_addr;
  logic [DATA_W-1:0] proc_wdata;
  logic              proc_gnt;
  logic [DATA_W-1:0] proc_rdata;
  logic              proc_rvalid;
  logic [ADDR_W-1:0] ddr_addr;
  logic [DATA_W-1:0] ddr_data_write;
  logic              ddr_en;
  logic              ddr_we;
  logic [DATA_W-1:0] data_read;
  logic [1:0]        owner;

  modport slave (
    input  pause, cam_req, cam_addr, cam_wdata, cam_urgent,
    input  proc_req, proc_we, proc_addr, proc_wdata, data_read,
    output cam_gnt, proc_gnt, proc_rdata, proc_rvalid,
    output ddr_addr, ddr_data_write, ddr_en, ddr_we, owner
  );

  modport master (
    output pause, cam_req, cam_addr, cam_wdata, cam_urgent,
    output proc_req, proc_we, proc_addr, proc_wdata, data_read,
    input  cam_gnt, proc_gnt, proc_rdata, proc_rvalid,
    input  ddr_addr, ddr_data_write, ddr_en, ddr_we, owner
  );
endinterface

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one DDR port between the camera writer and the processing engine.
// Optional DDR_ARB_URGENT_EN lets a near-full camera FIFO pre-empt a processing burst.
module ddr_port_arbiter #(
  parameter int unsigned ADDR_W       = 20,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned BURST_MAX    = 16,
  parameter int unsigned READ_LATENCY = 2
) (
  input logic               clk,
  input logic               rst_n,
  ddr_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCam  = 2'd1,
    StProc = 2'd2
  } state_e;

  localparam logic [7:0] BurstMax = 8'(BURST_MAX);

  state_e                  state_q, state_d;
  logic                    last_proc_q, last_proc_d;
  logic [7:0]              burst_cnt_q, burst_cnt_d, burst_inc;
  logic                    burst_hit;
  logic                    cam_gnt, proc_gnt, gnt, rd_gnt;
  logic                    cam_urgent_win;
  logic [ADDR_W-1:0]       ddr_addr_q;
  logic [DATA_W-1:0]       ddr_data_q;
  logic                    ddr_en_q, ddr_we_q;
  logic [READ_LATENCY-1:0] rd_pipe_q;
  logic                    rvalid_q;
  logic [DATA_W-1:0]       rdata_q;

`ifdef DDR_ARB_URGENT_EN
  assign cam_urgent_win = bus.cam_urgent & bus.cam_req;
`else
  logic unused_cam_urgent;
  assign unused_cam_urgent = bus.cam_urgent;
  assign cam_urgent_win    = 1'b0;
`endif

  assign cam_gnt  = (state_q == StCam) & bus.cam_req & ~bus.pause;
  assign proc_gnt = (state_q == StProc) & bus.proc_req & ~bus.pause;
  assign gnt      = cam_gnt | proc_gnt;
  assign rd_gnt   = proc_gnt & ~bus.proc_we;

  // Limit is judged on the count including this cycle's grant, so a burst is exactly BURST_MAX.
  assign burst_inc = burst_cnt_q + {7'd0, (gnt && (burst_cnt_q != 8'hFF))};
  assign burst_hit = (burst_inc >= BurstMax);

  always_comb begin
    state_d     = state_q;
    last_proc_d = last_proc_q;
    burst_cnt_d = burst_cnt_q;
    if (!bus.pause) begin
      unique case (state_q)
        StIdle: begin
          if (bus.cam_req && bus.proc_req) begin
            state_d = (last_proc_q || cam_urgent_win) ? StCam : StProc;
          end else if (bus.cam_req) begin
            state_d = StCam;
          end else if (bus.proc_req) begin
            state_d = StProc;
          end
        end
        StCam: begin
          if (!bus.cam_req) begin
            state_d = bus.proc_req ? StProc : StIdle;
          end else if (burst_hit && bus.proc_req) begin
            state_d = StProc;
          end
        end
        StProc: begin
          if (!bus.proc_req) begin
            state_d = bus.cam_req ? StCam : StIdle;
          end else if (bus.cam_req && (burst_hit || cam_urgent_win)) begin
            state_d = StCam;
          end
        end
        default: state_d = StIdle;
      endcase
      if ((state_d != state_q) && (state_q != StIdle)) begin
        last_proc_d = (state_q == StProc);
      end
      burst_cnt_d = (state_d != state_q) ? 8'd0 : burst_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      last_proc_q <= 1'b1;
      burst_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      last_proc_q <= last_proc_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // While paused the controller has not taken the current strobe, so everything holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ddr_addr_q <= '0;
      ddr_data_q <= '0;
      ddr_en_q   <= 1'b0;
      ddr_we_q   <= 1'b0;
      rd_pipe_q  <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else if (bus.pause) begin
      rvalid_q <= 1'b0;
    end else begin
      if (cam_gnt) begin
        ddr_addr_q <= bus.cam_addr;
        ddr_data_q <= bus.cam_wdata;
        ddr_we_q   <= 1'b1;
        ddr_en_q   <= 1'b1;
      end else if (proc_gnt) begin
        ddr_addr_q <= bus.proc_addr;
        ddr_data_q <= bus.proc_wdata;
        ddr_we_q   <= bus.proc_we;
        ddr_en_q   <= 1'b1;
      end else begin
        ddr_en_q <= 1'b0;
        ddr_we_q <= 1'b0;
      end
      rd_pipe_q <= (rd_pipe_q << 1) | READ_LATENCY'(rd_gnt);
      rvalid_q  <= rd_pipe_q[READ_LATENCY-1];
      if (rd_pipe_q[READ_LATENCY-1]) begin
        rdata_q <= bus.data_read;
      end
    end
  end

  assign bus.cam_gnt        = cam_gnt;
  assign bus.proc_gnt       = proc_gnt;
  assign bus.ddr_addr       = ddr_addr_q;
  assign bus.ddr_data_write = ddr_data_q;
  assign bus.ddr_en         = ddr_en_q;
  assign bus.ddr_we         = ddr_we_q;
  assign bus.proc_rvalid    = rvalid_q;
  assign bus.proc_rdata     = rdata_q;
  assign bus.owner          = state_q;

endmodule
